// File: rtl/hack_writeback.sv
// hack_writeback: commit stage that follows the 16-bit Hack ALU.
// It updates the A and D registers, resolves jumps, advances the PC, and sends
// stores to data memory over a valid/ready handshake. The stage stalls until
// each store has been accepted.
module hack_writeback #(
    parameter int WIDTH     = 16,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     instr,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 zr,
    input  logic                 ng,
    output logic [WIDTH-1:0]     a_reg,
    output logic [WIDTH-1:0]     d_reg,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_wr_valid,
    input  logic                 mem_wr_ready,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic {
        IDLE,
        MEM_WR
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_reg_q, a_reg_d;
    logic [WIDTH-1:0]     d_reg_q, d_reg_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                 mem_wr_valid_q, mem_wr_valid_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic                 is_c_instr;
    logic                 dest_a;
    logic                 dest_d;
    logic                 dest_m;
    logic                 jmp;
    logic [WIDTH-1:0]     pc_inc;
    logic [CNT_WIDTH-1:0] retired_inc;

    // Decode the instruction fields and the jump condition. The condition
    // uses the zr/ng flags that arrive with the instruction; it is never
    // re-derived from alu_out.
    always_comb begin
        is_c_instr  = instr[WIDTH-1];
        dest_a      = instr[5];
        dest_d      = instr[4];
        dest_m      = instr[3];
        jmp         = (instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr);
        pc_inc      = pc_q + WIDTH'(1);
        retired_inc = retired_q + CNT_WIDTH'(1);
    end

    // Next-state logic. In IDLE, every accepted instruction updates A, D and
    // the PC at once. A store moves the stage to MEM_WR, which holds the
    // request stable until memory takes it and then counts the instruction
    // as retired.
    always_comb begin
        state_d        = state_q;
        a_reg_d        = a_reg_q;
        d_reg_d        = d_reg_q;
        pc_d           = pc_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wr_valid_d = mem_wr_valid_q;
        retired_d      = retired_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_c_instr) begin
                        a_reg_d   = instr;
                        pc_d      = pc_inc;
                        retired_d = retired_inc;
                    end else begin
                        pc_d = jmp ? a_reg_q : pc_inc;
                        if (dest_a) begin
                            a_reg_d = alu_out;
                        end
                        if (dest_d) begin
                            d_reg_d = alu_out;
                        end
                        if (dest_m) begin
                            mem_addr_d     = a_reg_q;
                            mem_wdata_d    = alu_out;
                            mem_wr_valid_d = 1'b1;
                            state_d        = MEM_WR;
                        end else begin
                            retired_d = retired_inc;
                        end
                    end
                end
            end
            MEM_WR: begin
                if (mem_wr_ready) begin
                    mem_wr_valid_d = 1'b0;
                    retired_d      = retired_inc;
                    state_d        = IDLE;
                end
            end
        endcase
    end

    // State registers. Reset is synchronous and discards any pending store
    // without completing its handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            a_reg_q        <= '0;
            d_reg_q        <= '0;
            pc_q           <= WIDTH'(RESET_PC);
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wr_valid_q <= 1'b0;
            retired_q      <= '0;
        end else begin
            state_q        <= state_d;
            a_reg_q        <= a_reg_d;
            d_reg_q        <= d_reg_d;
            pc_q           <= pc_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            retired_q      <= retired_d;
        end
    end

    // Drive the outputs from the registers. in_ready depends only on state.
    always_comb begin
        in_ready     = (state_q == IDLE);
        a_reg        = a_reg_q;
        d_reg        = d_reg_q;
        pc           = pc_q;
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        mem_wr_valid = mem_wr_valid_q;
        retired      = retired_q;
    end

endmodule
